// File: rtl/linear_alloc_scheduler_pkg.sv
// Shared configuration for the linear allocation scheduler; values mirror TauCfg.
// Optional feature macro used by the top: LINEAR_SKIP_EN.
package linear_alloc_scheduler_pkg;

    localparam int TAU_LOCAL_ADDR_BW0 = 6;
    localparam int TAU_N_ICFG         = 2;
    localparam int TAU_DATA_BW        = 16;

endpackage

// File: rtl/linear_credit_counter.sv
// Free-space register for the linear ring: one increment (release) and one
// decrement (allocate) port, both usable in the same cycle; resets to full.
module linear_credit_counter #(
    parameter int LBW = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         inc_en,
    input  logic [LBW:0] inc_amt,
    input  logic         dec_en,
    input  logic [LBW:0] dec_amt,
    output logic [LBW:0] o_free
);

    localparam logic [LBW:0] CAP = {1'b1, {LBW{1'b0}}};

    logic [LBW:0] inc_v, dec_v;

    assign inc_v = inc_en ? inc_amt : '0;
    assign dec_v = dec_en ? dec_amt : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_free <= CAP;
        else        o_free <= o_free + inc_v - dec_v;
    end

    assert property (@(posedge i_clk) disable iff (!i_rst) o_free <= CAP);

endmodule

// File: rtl/linear_alloc_scheduler.sv
// Issues one linear-ring allocation per (block, config id) and returns space on
// in-order releases. Define LINEAR_SKIP_EN to add per-id skip (zero-size) allocs.
module linear_alloc_scheduler
    import linear_alloc_scheduler_pkg::*;
#(
    parameter int  LBW     = TAU_LOCAL_ADDR_BW0,
    parameter int  N_ICFG  = TAU_N_ICFG,
    parameter int  DBW     = TAU_DATA_BW,
    localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         cfg_rdy,
    output logic                         cfg_ack,
    input  logic [N_ICFG-1:0][LBW:0]     i_sizes,
    input  logic [N_ICFG-1:0][DBW-1:0]   i_padvs,
    input  logic [15:0]                  i_nblk,
`ifdef LINEAR_SKIP_EN
    input  logic [N_ICFG-1:0]            i_skip_mask,
    output logic                         o_skip,
`endif
    output logic                         alloc_linear_rdy,
    input  logic                         alloc_linear_ack,
    output logic [LBW-1:0]               o_linear,
    output logic [ICFG_BW-1:0]           o_linear_id,
    output logic [LBW:0]                 o_size,
    output logic [DBW-1:0]               o_padv,
    input  logic                         done_linear_rdy,
    output logic                         done_linear_ack,
    input  logic [ICFG_BW-1:0]           i_linear_id,
    output logic                         o_busy
);

    localparam logic [LBW:0] CAP = {1'b1, {LBW{1'b0}}};

    typedef enum logic [1:0] {IDLE, ALLOC, DRAIN} state_t;

    typedef struct packed {
        logic               skip;
        logic [ICFG_BW-1:0] id;
        logic [LBW:0]       size;
        logic [DBW-1:0]     padv;
    } alloc_t;

    state_t                     state, state_nxt;
    alloc_t                     cur;
    logic [LBW-1:0]             wptr;
    logic [N_ICFG-1:0][LBW:0]   sizes_r;
    logic [N_ICFG-1:0][DBW-1:0] padvs_r;
    logic [N_ICFG-1:0]          skip_r, skip_in;
    logic [15:0]                nblk_r, blk;
    logic [LBW:0]               outstanding, free_cnt, inc_amt, dec_amt;
    logic                       alloc_fire, done_fire, last_id, last_blk;
    logic [ICFG_BW-1:0]         id_nxt;

    // Descriptor for one config id; out-of-range ids resolve to an all-zero entry.
    function automatic alloc_t pick(input logic [ICFG_BW-1:0] id,
                                    input logic [N_ICFG-1:0][LBW:0]   sizes,
                                    input logic [N_ICFG-1:0][DBW-1:0] padvs,
                                    input logic [N_ICFG-1:0]          skip);
        alloc_t a;
        a    = '0;
        a.id = id;
        for (int k = 0; k < N_ICFG; k++) begin
            if (id == ICFG_BW'(k)) begin
                a.size = sizes[k];
                a.padv = padvs[k];
                a.skip = skip[k];
            end
        end
        return a;
    endfunction

`ifdef LINEAR_SKIP_EN
    assign skip_in = i_skip_mask;
    assign o_skip  = cur.skip;
`else
    assign skip_in = '0;
`endif

    assign alloc_fire = alloc_linear_rdy && alloc_linear_ack;
    assign done_fire  = done_linear_ack;
    assign last_id    = (cur.id == ICFG_BW'(N_ICFG - 1));
    assign last_blk   = (blk == nblk_r - 16'd1);
    assign id_nxt     = last_id ? '0 : cur.id + 1'b1;

    assign o_linear    = wptr;
    assign o_linear_id = cur.id;
    assign o_size      = cur.size;
    assign o_padv      = cur.padv;

    // Skipped entries take no space and give none back.
    assign dec_amt = cur.skip ? '0 : cur.size;
    always_comb begin
        inc_amt = '0;
        for (int k = 0; k < N_ICFG; k++) begin
            if (i_linear_id == ICFG_BW'(k) && !skip_r[k]) inc_amt = sizes_r[k];
        end
    end

    linear_credit_counter #(.LBW(LBW)) u_credit (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .inc_en  (done_fire),
        .inc_amt (inc_amt),
        .dec_en  (alloc_fire),
        .dec_amt (dec_amt),
        .o_free  (free_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_ack && i_nblk != 16'd0)          state_nxt = ALLOC;
            ALLOC:   if (alloc_fire && last_id && last_blk)   state_nxt = DRAIN;
            DRAIN:   if (outstanding == '0)                   state_nxt = IDLE;
            default:                                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ack          = (state == IDLE) && cfg_rdy;
        alloc_linear_rdy = (state == ALLOC) && (cur.skip || free_cnt >= cur.size);
        done_linear_ack  = (state == ALLOC || state == DRAIN) && done_linear_rdy
                           && (outstanding != '0);
        o_busy           = (state != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr        <= '0;
            cur         <= '0;
            sizes_r     <= '0;
            padvs_r     <= '0;
            skip_r      <= '0;
            nblk_r      <= '0;
            blk         <= '0;
            outstanding <= '0;
        end else begin
            if (cfg_ack) begin
                sizes_r <= i_sizes;
                padvs_r <= i_padvs;
                skip_r  <= skip_in;
                nblk_r  <= i_nblk;
                blk     <= '0;
                cur     <= pick('0, i_sizes, i_padvs, skip_in);
            end
            if (alloc_fire) begin
                if (!cur.skip) wptr <= wptr + cur.size[LBW-1:0];
                cur <= pick(id_nxt, sizes_r, padvs_r, skip_r);
                if (last_id) blk <= blk + 16'd1;
            end
            case ({alloc_fire, done_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst) outstanding <= CAP);

endmodule

// File: tb/tb_linear_alloc_scheduler.sv
// Directed bench for linear_alloc_scheduler (LBW=6, N_ICFG=2); the skip case
// runs only when LINEAR_SKIP_EN is defined.
module tb_linear_alloc_scheduler;

    localparam int LBW = 6;
    localparam int NI  = 2;
    localparam int DBW = 16;
    localparam int IBW = 2;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  cfg_rdy, cfg_ack;
    logic [NI-1:0][LBW:0]  i_sizes;
    logic [NI-1:0][DBW-1:0] i_padvs;
    logic [15:0]           i_nblk;
`ifdef LINEAR_SKIP_EN
    logic [NI-1:0]         i_skip_mask;
    logic                  o_skip;
`endif
    logic                  alloc_linear_rdy, alloc_linear_ack;
    logic [LBW-1:0]        o_linear;
    logic [IBW-1:0]        o_linear_id;
    logic [LBW:0]          o_size;
    logic [DBW-1:0]        o_padv;
    logic                  done_linear_rdy, done_linear_ack;
    logic [IBW-1:0]        i_linear_id;
    logic                  o_busy;

    int errors = 0;
    int checks = 0;
    int iss_lin [8];
    int iss_id  [8];
    int iss_padv[8];
    int n_iss;

    linear_alloc_scheduler #(.LBW(LBW), .N_ICFG(NI), .DBW(DBW)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .cfg_rdy          (cfg_rdy),
        .cfg_ack          (cfg_ack),
        .i_sizes          (i_sizes),
        .i_padvs          (i_padvs),
        .i_nblk           (i_nblk),
`ifdef LINEAR_SKIP_EN
        .i_skip_mask      (i_skip_mask),
        .o_skip           (o_skip),
`endif
        .alloc_linear_rdy (alloc_linear_rdy),
        .alloc_linear_ack (alloc_linear_ack),
        .o_linear         (o_linear),
        .o_linear_id      (o_linear_id),
        .o_size           (o_size),
        .o_padv           (o_padv),
        .done_linear_rdy  (done_linear_rdy),
        .done_linear_ack  (done_linear_ack),
        .i_linear_id      (i_linear_id),
        .o_busy           (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        cfg_rdy = 1'b0; alloc_linear_ack = 1'b0; done_linear_rdy = 1'b0;
        i_linear_id = '0; i_nblk = '0; i_sizes = '0; i_padvs = '0;
`ifdef LINEAR_SKIP_EN
        i_skip_mask = '0;
`endif
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    // Leaves the bench at the first negedge after the cfg handshake edge.
    task automatic start_job(input logic [LBW:0] s0, input logic [LBW:0] s1,
                             input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] nb);
        @(negedge i_clk);
        i_sizes[0] = s0; i_sizes[1] = s1;
        i_padvs[0] = p0; i_padvs[1] = p1;
        i_nblk = nb; cfg_rdy = 1'b1;
        #1 chk("cfg_ack", cfg_ack, 1);
        @(negedge i_clk);
        cfg_rdy = 1'b0;
    endtask

    // Collector model: acks every alloc at once, releases each one dly cycles later.
    task automatic run_job(input int dly);
        int rel_t[$];
        int rel_id[$];
        int t;
        t = 0; n_iss = 0;
        alloc_linear_ack = 1'b1;
        while (t < 200) begin
            if (rel_t.size() > 0 && rel_t[0] <= t) begin
                done_linear_rdy = 1'b1;
                i_linear_id = IBW'(rel_id[0]);
            end else begin
                done_linear_rdy = 1'b0;
            end
            #1;
            if (done_linear_ack) begin
                void'(rel_t.pop_front());
                void'(rel_id.pop_front());
            end
            if (alloc_linear_rdy && n_iss < 8) begin
                iss_lin[n_iss] = int'(o_linear);
                iss_id[n_iss] = int'(o_linear_id);
                iss_padv[n_iss] = int'(o_padv);
                n_iss++;
                rel_t.push_back(t + dly);
                rel_id.push_back(int'(o_linear_id));
            end
            if (!o_busy && n_iss > 0) break;
            @(negedge i_clk);
            t++;
        end
        alloc_linear_ack = 1'b0;
        done_linear_rdy = 1'b0;
        chk("job_finished_in_budget", t < 200, 1);
    endtask

    initial begin
        do_reset();
        i_rst = 1'b0;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_alloc_rdy", alloc_linear_rdy, 0);
        chk("rst_done_ack", done_linear_ack, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_linear", o_linear, 0);
        chk("rst_size", o_size, 0);
        chk("rst_free", dut.free_cnt, 64);
        @(negedge i_clk);
        i_rst = 1'b1;

        // 1: sizes {16,8}, two blocks, release three cycles after issue
        start_job(7'd16, 7'd8, 16'hAAAA, 16'h5555, 16'd2);
        run_job(3);
        chk("s1_count", n_iss, 4);
        chk("s1_lin0", iss_lin[0], 0);
        chk("s1_lin1", iss_lin[1], 16);
        chk("s1_lin2", iss_lin[2], 24);
        chk("s1_lin3", iss_lin[3], 40);
        chk("s1_id0", iss_id[0], 0);
        chk("s1_id1", iss_id[1], 1);
        chk("s1_id2", iss_id[2], 0);
        chk("s1_id3", iss_id[3], 1);
        chk("s1_padv0", iss_padv[0], 32'hAAAA);
        chk("s1_padv1", iss_padv[1], 32'h5555);
        chk("s1_free_end", dut.free_cnt, 64);

        // 2: sizes {40,30}, second alloc blocked until id0 returns
        do_reset();
        start_job(7'd40, 7'd30, 16'd1, 16'd2, 16'd1);
        alloc_linear_ack = 1'b1;
        #1 chk("s2_first_rdy", alloc_linear_rdy, 1);
        chk("s2_lin0", o_linear, 0);
        chk("s2_size0", o_size, 40);
        @(negedge i_clk); #1;
        chk("s2_blocked_rdy", alloc_linear_rdy, 0);
        chk("s2_blocked_free", dut.free_cnt, 24);
        chk("s2_blocked_lin", o_linear, 40);
        chk("s2_blocked_id", o_linear_id, 1);
        chk("s2_blocked_size", o_size, 30);
        @(negedge i_clk);
        done_linear_rdy = 1'b1; i_linear_id = 2'd0;
        #1 chk("s2_still_blocked", alloc_linear_rdy, 0);
        chk("s2_lin_stable", o_linear, 40);
        chk("s2_rel0_ack", done_linear_ack, 1);
        @(negedge i_clk);
        done_linear_rdy = 1'b0;
        #1 chk("s2_free_full", dut.free_cnt, 64);
        chk("s2_rdy_after_rel", alloc_linear_rdy, 1);
        chk("s2_lin1", o_linear, 40);
        @(negedge i_clk);
        alloc_linear_ack = 1'b0;
        #1 chk("s2_drain_busy", o_busy, 1);
        chk("s2_drain_rdy", alloc_linear_rdy, 0);
        done_linear_rdy = 1'b1; i_linear_id = 2'd1;
        #1 chk("s2_rel1_ack", done_linear_ack, 1);
        @(negedge i_clk); #1;
        chk("s2_holdoff_ack", done_linear_ack, 0);
        chk("s2_busy_before_idle", o_busy, 1);
        @(negedge i_clk);
        done_linear_rdy = 1'b0;
        #1 chk("s2_idle", o_busy, 0);

        // 3: wrap with {48,32}, immediate release
        do_reset();
        start_job(7'd48, 7'd32, 16'd3, 16'd4, 16'd2);
        run_job(1);
        chk("s3_count", n_iss, 4);
        chk("s3_lin0", iss_lin[0], 0);
        chk("s3_lin1", iss_lin[1], 48);
        chk("s3_lin2", iss_lin[2], 16);
        chk("s3_lin3", iss_lin[3], 0);

        // 4: release of 16 in the same cycle as an 8-word alloc
        do_reset();
        start_job(7'd16, 7'd8, 16'd5, 16'd6, 16'd1);
        alloc_linear_ack = 1'b1;
        #1 chk("s4_rdy0", alloc_linear_rdy, 1);
        @(negedge i_clk);
        done_linear_rdy = 1'b1; i_linear_id = 2'd0;
        #1 chk("s4_rdy1", alloc_linear_rdy, 1);
        chk("s4_rel_ack", done_linear_ack, 1);
        chk("s4_free_before", dut.free_cnt, 48);
        chk("s4_out_before", dut.outstanding, 1);
        @(negedge i_clk);
        alloc_linear_ack = 1'b0; done_linear_rdy = 1'b0;
        #1 chk("s4_free_after", dut.free_cnt, 56);
        chk("s4_out_after", dut.outstanding, 1);

        // 5: empty job, then async reset in the middle of ALLOC
        do_reset();
        @(negedge i_clk);
        i_nblk = 16'd0; cfg_rdy = 1'b1;
        #1 chk("s5_cfg_ack_nblk0", cfg_ack, 1);
        @(negedge i_clk);
        cfg_rdy = 1'b0;
        #1 chk("s5_nblk0_busy", o_busy, 0);
        chk("s5_nblk0_rdy", alloc_linear_rdy, 0);
        @(negedge i_clk); #1;
        chk("s5_nblk0_rdy_later", alloc_linear_rdy, 0);
        start_job(7'd16, 7'd8, 16'h77, 16'h88, 16'd2);
        alloc_linear_ack = 1'b1;
        @(negedge i_clk);
        alloc_linear_ack = 1'b0;
        #1 chk("s5_mid_lin", o_linear, 16);
        #2 i_rst = 1'b0;
        #1 chk("s5_rst_lin", o_linear, 0);
        chk("s5_rst_busy", o_busy, 0);
        chk("s5_rst_rdy", alloc_linear_rdy, 0);
        chk("s5_rst_size", o_size, 0);
        chk("s5_rst_id", o_linear_id, 0);
        chk("s5_rst_padv", o_padv, 0);
        chk("s5_rst_free", dut.free_cnt, 64);
        @(negedge i_clk);
        i_rst = 1'b1;
        start_job(7'd16, 7'd8, 16'h77, 16'h88, 16'd1);
        #1 chk("s5_new_rdy", alloc_linear_rdy, 1);
        chk("s5_new_lin", o_linear, 0);

`ifdef LINEAR_SKIP_EN
        // 6: id1 skipped, issued regardless of free space
        do_reset();
        i_skip_mask = 2'b10;
        start_job(7'd8, 7'd64, 16'd9, 16'd10, 16'd1);
        alloc_linear_ack = 1'b1;
        #1 chk("s6_skip0", o_skip, 0);
        chk("s6_lin0", o_linear, 0);
        @(negedge i_clk); #1;
        chk("s6_skip1", o_skip, 1);
        chk("s6_rdy1", alloc_linear_rdy, 1);
        chk("s6_free1", dut.free_cnt, 56);
        chk("s6_lin1", o_linear, 8);
        @(negedge i_clk);
        alloc_linear_ack = 1'b0;
        #1 chk("s6_wptr_kept", o_linear, 8);
        done_linear_rdy = 1'b1; i_linear_id = 2'd0;
        @(negedge i_clk);
        i_linear_id = 2'd1;
        @(negedge i_clk);
        done_linear_rdy = 1'b0;
        #1 chk("s6_free_end", dut.free_cnt, 64);
        chk("s6_out_end", dut.outstanding, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
